// File: rtl/idp_seq_pkg.sv
// Shared encodings for the integer-datapath sequencer: states, MIPS opcode/funct
// values, ALU function codes, write-back/destination selects and the decode bundle.
package idp_seq_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_ADDU   = 5'h03;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SUBU   = 5'h05;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_SLTU   = 5'h07;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_XOR    = 5'h0A;
    localparam logic [4:0] FS_NOR    = 5'h0B;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    localparam logic [2:0] YS_ALU = 3'd0;
    localparam logic [2:0] YS_PC  = 3'd1;
    localparam logic [2:0] YS_DY  = 3'd2;
    localparam logic [2:0] YS_LO  = 3'd3;
    localparam logic [2:0] YS_HI  = 3'd4;

    localparam logic [1:0] DA_RD = 2'd0;
    localparam logic [1:0] DA_RT = 2'd1;
    localparam logic [1:0] DA_RA = 2'd2;
    localparam logic [1:0] DA_SP = 2'd3;

    typedef struct packed {
        logic [4:0] fs;
        logic       hilo;
        logic       wr;
        logic [2:0] ysel;
        logic [1:0] dasel;
        logic       tsel;
        logic       sext;
        logic       ovf_chk;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/idp_seq_if.sv
// Fetch-side handshake between the instruction source and the sequencer.
interface idp_seq_if #(
    parameter int SEQ_W = 32
);
    logic [SEQ_W-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/idp_seq_decode.sv
// Combinational opcode/funct decode into the datapath control bundle; the
// sequencer gates each field by state.
module idp_seq_decode
    import idp_seq_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (op)
            OP_RTYPE: begin
                ctrl.wr = 1'b1;
                case (funct)
                    FN_ADD:  begin ctrl.fs = FS_ADD; ctrl.ovf_chk = 1'b1; end
                    FN_ADDU: ctrl.fs = FS_ADDU;
                    FN_SUB:  begin ctrl.fs = FS_SUB; ctrl.ovf_chk = 1'b1; end
                    FN_SUBU: ctrl.fs = FS_SUBU;
                    FN_AND:  ctrl.fs = FS_AND;
                    FN_OR:   ctrl.fs = FS_OR;
                    FN_XOR:  ctrl.fs = FS_XOR;
                    FN_NOR:  ctrl.fs = FS_NOR;
                    FN_SLT:  ctrl.fs = FS_SLT;
                    FN_SLTU: ctrl.fs = FS_SLTU;
                    FN_MULT, FN_MULTU: begin ctrl.fs = FS_MUL; ctrl.hilo = 1'b1; ctrl.wr = 1'b0; end
                    FN_DIV, FN_DIVU:   begin ctrl.fs = FS_DIV; ctrl.hilo = 1'b1; ctrl.wr = 1'b0; end
                    FN_MFHI: ctrl.ysel = YS_HI;
                    FN_MFLO: ctrl.ysel = YS_LO;
                    default: begin ctrl.wr = 1'b0; ctrl.illegal = 1'b1; end
                endcase
            end
            OP_JAL: begin
                ctrl.fs    = FS_PASS_S;
                ctrl.ysel  = YS_PC;
                ctrl.dasel = DA_RA;
                ctrl.wr    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.tsel  = 1'b1;
                ctrl.dasel = DA_RT;
                ctrl.wr    = 1'b1;
                case (op)
                    OP_ADDI:  begin ctrl.fs = FS_ADD; ctrl.sext = 1'b1; ctrl.ovf_chk = 1'b1; end
                    OP_ADDIU: begin ctrl.fs = FS_ADDU; ctrl.sext = 1'b1; end
                    OP_SLTI:  begin ctrl.fs = FS_SLT; ctrl.sext = 1'b1; end
                    OP_SLTIU: begin ctrl.fs = FS_SLTU; ctrl.sext = 1'b1; end
                    OP_ANDI:  ctrl.fs = FS_AND;
                    OP_ORI:   ctrl.fs = FS_OR;
                    default:  ctrl.fs = FS_XOR;
                endcase
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/idp_sequencer.sv
// Four-state controller sequencing one instruction through the integer datapath.
// Define IDP_SEQ_OVF_TRAP_EN to suppress add/sub/addi write-back on signed overflow.
module idp_sequencer
    import idp_seq_pkg::*;
#(
    parameter int SEQ_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    idp_seq_if.slave         fetch,
    input  logic             V,
    output logic [4:0]       FS,
    output logic             HILO_ld,
    output logic             D_En,
    output logic [4:0]       D_Addr,
    output logic [4:0]       S_Addr,
    output logic [4:0]       T_Addr,
    output logic [SEQ_W-1:0] DT,
    output logic             T_Sel,
    output logic [2:0]       Y_Sel,
    output logic [1:0]       DA_sel,
    output logic             busy,
    output logic             done,
    output logic             illegal
`ifdef IDP_SEQ_OVF_TRAP_EN
    ,
    output logic             ovf
`endif
);

    // state  | meaning
    // IDLE   | instr_ready high, waiting for instr_valid
    // DECODE | register addresses and immediate presented, RS/RT latched
    // EXEC   | FS (and HILO_ld) presented, ALU result latched
    // WB     | write-back select/destination presented, done pulses

    logic [1:0]       state;
    logic [SEQ_W-1:0] ir;
    ctrl_t            ctrl;
    logic             in_wb;
    logic             trap;

    idp_seq_decode u_decode (
        .op    (ir[31:26]),
        .funct (ir[5:0]),
        .ctrl  (ctrl)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch.instr_valid) begin
                        ir    <= fetch.instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC:   state <= S_WB;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef IDP_SEQ_OVF_TRAP_EN
    logic v_q;

    always_ff @(posedge CLK) begin
        if (RESET)
            v_q <= 1'b0;
        else if (state == S_EXEC)
            v_q <= V;
    end

    assign trap = ctrl.ovf_chk & v_q;
    assign ovf  = in_wb & trap;
`else
    logic [1:0] ovf_unused;
    assign ovf_unused = {V, ctrl.ovf_chk};
    assign trap       = 1'b0;
`endif

    assign in_wb             = (state == S_WB);
    assign fetch.instr_ready = (state == S_IDLE);
    assign busy              = (state != S_IDLE);

    assign S_Addr = ir[25:21];
    assign T_Addr = ir[20:16];
    assign D_Addr = ir[15:11];
    assign DT     = {{(SEQ_W-16){ctrl.sext & ir[15]}}, ir[15:0]};

    assign T_Sel   = (state == S_DECODE) & ctrl.tsel;
    assign FS      = (state == S_EXEC) ? ctrl.fs : FS_PASS_S;
    assign HILO_ld = (state == S_EXEC) & ctrl.hilo;
    assign Y_Sel   = in_wb ? ctrl.ysel : YS_ALU;
    assign DA_sel  = in_wb ? ctrl.dasel : DA_RD;
    assign D_En    = in_wb & ctrl.wr & ~trap;
    assign done    = in_wb;
    assign illegal = in_wb & ctrl.illegal;

endmodule

// File: tb/tb_idp_sequencer.sv
// Scoreboard bench for idp_sequencer: driver pushes reference-model expectations
// on each accept, a negedge monitor checks every phase of the transaction.
module tb_idp_sequencer;

    typedef struct {
        logic [4:0]  s, t, d;
        logic [31:0] dt;
        logic        tsel;
        logic [4:0]  fs;
        logic        hilo, wr;
        logic [2:0]  ysel;
        logic [1:0]  dasel;
        logic        bad, trap;
    } exp_t;

`ifdef IDP_SEQ_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        V;
    logic [4:0]  FS;
    logic        HILO_ld, D_En, T_Sel, busy, done, illegal;
    logic [4:0]  D_Addr, S_Addr, T_Addr;
    logic [31:0] DT;
    logic [2:0]  Y_Sel;
    logic [1:0]  DA_sel;
`ifdef IDP_SEQ_OVF_TRAP_EN
    logic        ovf;
`endif

    idp_seq_if #(.SEQ_W(32)) fetch_if ();

    idp_sequencer #(.SEQ_W(32)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .fetch   (fetch_if),
        .V       (V),
        .FS      (FS),
        .HILO_ld (HILO_ld),
        .D_En    (D_En),
        .D_Addr  (D_Addr),
        .S_Addr  (S_Addr),
        .T_Addr  (T_Addr),
        .DT      (DT),
        .T_Sel   (T_Sel),
        .Y_Sel   (Y_Sel),
        .DA_sel  (DA_sel),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
`ifdef IDP_SEQ_OVF_TRAP_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;
    int   n_abort = 0;
    int   n_done = 0;
    bit   v_force = 1'b0;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each MIPS encoding must make the datapath do.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] op, fn;
        logic signed_imm;
        op = w[31:26];
        fn = w[5:0];
        signed_imm = 1'b0;
        e.s = w[25:21]; e.t = w[20:16]; e.d = w[15:11];
        e.tsel = 0; e.fs = 0; e.hilo = 0; e.wr = 0; e.ysel = 0; e.dasel = 0; e.bad = 0; e.trap = 0;
        if (op == 6'h00) begin
            e.wr = 1'b1;
            case (fn)
                6'h20: begin e.fs = 5'h02; e.trap = 1'b1; end
                6'h21: e.fs = 5'h03;
                6'h22: begin e.fs = 5'h04; e.trap = 1'b1; end
                6'h23: e.fs = 5'h05;
                6'h24: e.fs = 5'h08;
                6'h25: e.fs = 5'h09;
                6'h26: e.fs = 5'h0A;
                6'h27: e.fs = 5'h0B;
                6'h2A: e.fs = 5'h06;
                6'h2B: e.fs = 5'h07;
                6'h18, 6'h19: begin e.fs = 5'h1E; e.hilo = 1'b1; e.wr = 1'b0; end
                6'h1A, 6'h1B: begin e.fs = 5'h1F; e.hilo = 1'b1; e.wr = 1'b0; end
                6'h10: e.ysel = 3'd4;
                6'h12: e.ysel = 3'd3;
                default: begin e.bad = 1'b1; e.wr = 1'b0; end
            endcase
        end else if (op == 6'h03) begin
            e.wr = 1'b1; e.ysel = 3'd1; e.dasel = 2'd2; e.fs = 5'h00;
        end else if (op >= 6'h08 && op <= 6'h0E) begin
            signed_imm = (op <= 6'h0B);
            e.trap = (op == 6'h08);
            case (op)
                6'h08: e.fs = 5'h02;
                6'h09: e.fs = 5'h03;
                6'h0A: e.fs = 5'h06;
                6'h0B: e.fs = 5'h07;
                6'h0C: e.fs = 5'h08;
                6'h0D: e.fs = 5'h09;
                default: e.fs = 5'h0A;
            endcase
            e.tsel = 1'b1; e.dasel = 2'd1; e.wr = 1'b1;
        end else begin
            e.bad = 1'b1;
        end
        e.dt = signed_imm ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
        return e;
    endfunction

    // Present w until accepted; afterwards show junk for `gap` busy cycles.
    task automatic send(input logic [31:0] w, input int gap, output time t_acc);
        bit ok;
        ok = 1'b0;
        t_acc = 0;
        fetch_if.instr = w;
        fetch_if.instr_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (fetch_if.instr_ready && !RESET) begin
                q.push_back(model(w));
                n_acc++;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            fetch_if.instr_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        t_acc = $time;
        #1;
        fetch_if.instr = $urandom;
        fetch_if.instr_valid = (gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        fetch_if.instr_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            V = v_force ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: phase 1/2/3 = DECODE/EXEC/WB, counted from the start of busy.
    initial begin
        int   phase;
        logic v_exec;
        exp_t e;
        phase = 0;
        v_exec = 1'b0;
        forever begin
            @(negedge CLK);
            if (!busy) begin
                phase = 0;
                chk("idle_ready", fetch_if.instr_ready, 1'b1);
                chk("idle_quiet", {D_En, done, HILO_ld, T_Sel, illegal, FS, Y_Sel, DA_sel}, 32'd0);
            end else begin
                phase++;
                if (q.size() == 0) begin
                    chk("busy_without_accept", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    chk("busy_not_ready", fetch_if.instr_ready, 1'b0);
                    case (phase)
                        1: begin
                            chk("dec_s_addr", S_Addr, e.s);
                            chk("dec_t_addr", T_Addr, e.t);
                            chk("dec_t_sel", T_Sel, e.tsel);
                            if (e.tsel) chk("dec_dt", DT, e.dt);
                            chk("dec_quiet", {D_En, done, HILO_ld, FS, Y_Sel, DA_sel}, 32'd0);
                        end
                        2: begin
                            chk("exec_fs", FS, e.fs);
                            chk("exec_hilo", HILO_ld, e.hilo);
                            chk("exec_quiet", {D_En, done, T_Sel, Y_Sel, DA_sel}, 32'd0);
                            v_exec = V;
                        end
                        3: begin
                            chk("wb_done", done, 1'b1);
                            chk("wb_d_en", D_En, e.wr && !(TRAP_EN && e.trap && v_exec));
                            chk("wb_d_addr", D_Addr, e.d);
                            chk("wb_t_addr", T_Addr, e.t);
                            chk("wb_y_sel", Y_Sel, e.ysel);
                            chk("wb_da_sel", DA_sel, e.dasel);
                            chk("wb_illegal", illegal, e.bad);
                            chk("wb_quiet", {HILO_ld, T_Sel, FS}, 32'd0);
`ifdef IDP_SEQ_OVF_TRAP_EN
                            chk("wb_ovf", ovf, e.trap && v_exec);
`endif
                            void'(q.pop_front());
                            n_done++;
                        end
                        default: chk("busy_too_long", phase, 32'd3);
                    endcase
                end
            end
            if (RESET) q.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        time t_acc, t_prev;
        logic [31:0] w;
        logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
        logic [31:0] plan [7] = '{32'h00221820, 32'h2005FFFF, 32'h3405FFFF, 32'h00220018,
                                  32'h00002012, 32'h0C000010, 32'hFC000000};
        RESET = 1'b1;
        V = 1'b0;
        fetch_if.instr = 32'h0;
        fetch_if.instr_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ready", fetch_if.instr_ready, 1'b1);
        chk("reset_outputs", {busy, D_En, done, HILO_ld, T_Sel, illegal, FS, Y_Sel, DA_sel,
                              S_Addr, T_Addr, D_Addr}, 32'd0);
        chk("reset_dt", DT, 32'd0);
        RESET = 1'b0;

        foreach (plan[i]) send(plan[i], $urandom_range(0, 3), t_acc);

        v_force = 1'b1;
        send(32'h00221820, 0, t_acc);
        send(32'h2001FFFF, 0, t_acc);
        repeat (4) @(posedge CLK);
        #1;
        v_force = 1'b0;

        // Abort during EXEC: reset lands on the EXEC->WB edge.
        send(32'h00221820, 0, t_acc);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        n_abort++;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("abort_ready", fetch_if.instr_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_d_en", D_En, 1'b0);

        // instr_valid held high: one accept every four cycles.
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            w = 32'h00221820 | (32'($urandom_range(0, 31)) << 11);
            send(w, 0, t_acc);
            if (i > 0) chk("throughput_gap", 32'(t_acc - t_prev), 32'd40);
            t_prev = t_acc;
        end

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    w[31:26] = 6'h00;
                    w[5:0] = rfn[$urandom_range(0, 15)];
                end
                4, 5, 6: w[31:26] = 6'($urandom_range(8, 14));
                7: w[31:26] = 6'h03;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
            send(w, $urandom_range(0, 3), t_acc);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
        @(negedge CLK);
        chk("queue_drained", q.size(), 32'd0);
        chk("done_count", n_done, n_acc - n_abort);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idp_sequencer.md
Name: idp_sequencer

Overview:
- Multi-cycle control FSM that sequences the integer datapath: fetch handshake → register read → ALU execute → write-back.
- Accepts one 32-bit MIPS-format instruction per transaction and drives every datapath control input (FS, HILO_ld, D_En, address fields, DT/T_Sel, Y_Sel, DA_sel) cycle by cycle.
- Sits between the instruction source (IR / fetch unit) and the integer datapath.

Parameters:
- SEQ_W, 32, instruction and immediate data width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- instr  in  32  instruction word.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  sequencer can accept.
- V  in  1  ALU signed-overflow flag.
- FS  out  5  ALU function select.
- HILO_ld  out  1  HI/LO load.
- D_En  out  1  register-file write enable.
- D_Addr  out  5  IR[15:11].
- S_Addr  out  5  IR[25:21].
- T_Addr  out  5  IR[20:16].
- DT  out  32  extended immediate.
- T_Sel  out  1  1 = ALU T operand from DT.
- Y_Sel  out  3  write-back source: 0 ALU, 1 PC_in, 2 DY, 3 LO, 4 HI.
- DA_sel  out  2  destination: 0 rd, 1 rt, 2 $31, 3 $29.
- busy  out  1  transaction in flight.
- done  out  1  one-cycle pulse in the write-back cycle.
- illegal  out  1  one-cycle pulse with done for an unsupported encoding.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, as already decided.
- On reset: state=IDLE, IR=0. All outputs are 0 except instr_ready, which is 1. Reset in any state aborts the transaction with no further D_En/HILO_ld.
- States:
  - IDLE: instr_ready=1. On instr_valid, latch IR, go to DECODE.
  - DECODE: S_Addr, T_Addr and DT/T_Sel are valid. The datapath latches RS/RT at the end of this cycle. Next state EXEC.
  - EXEC: FS is valid. HILO_ld=1 only for mult/multu/div/divu. The datapath latches the ALU result at the end of this cycle. Next state WB.
  - WB: Y_Sel, DA_sel and D_Addr are valid. D_En=1 for writing instructions. done=1. Next state IDLE.
- instr_ready=0 and busy=1 in DECODE, EXEC and WB. instr_valid is ignored while busy.
- Fixed latency: done is asserted 3 cycles after the accepting edge. Throughput is 1 instruction per 4 cycles.
- S_Addr, T_Addr, D_Addr and DT derive from IR and are held stable for the whole transaction. FS, HILO_ld, D_En, Y_Sel, DA_sel and T_Sel are 0 outside their active state.
- Supported encodings:
  - R-type add/addu/sub/subu/and/or/xor/nor/slt/sltu: DA_sel=0, Y_Sel=0, D_En=1.
  - mult/multu/div/divu: D_En=0.
  - mfhi: Y_Sel=4, D_En=1. mflo: Y_Sel=3, D_En=1.
  - addi/addiu/slti/sltiu: sign-extend IR[15:0].
  - andi/ori/xori: zero-extend IR[15:0].
  - All immediate forms: T_Sel=1, DA_sel=1, D_En=1.
  - jal: Y_Sel=1, DA_sel=2, D_En=1, FS=PASS_S.
- Any other opcode/funct: complete the FSM normally with D_En=0 and HILO_ld=0. illegal=1 together with done.
- A write to $0 is still issued; the register file is responsible for ignoring it.

Optional Feature:
- Macro IDP_SEQ_OVF_TRAP_EN.
- Defined:
  - For add/sub/addi, V is registered at the end of EXEC.
  - If it is 1, D_En is forced to 0 in WB and the output ovf (1 bit, added only under this macro) pulses with done.
- Undefined: V is unused; overflowing results are written normally.

Decomposition:
- Package idp_seq_pkg:
  - State enum (IDLE, DECODE, EXEC, WB).
  - Opcode/funct constants.
  - FS codes: PASS_S=5'h00, ADD=5'h02, ADDU=5'h03, SUB=5'h04, SUBU=5'h05, SLT=5'h06, SLTU=5'h07, AND=5'h08, OR=5'h09, XOR=5'h0A, NOR=5'h0B, MUL=5'h1E, DIV=5'h1F.
  - Y_Sel/DA_sel encodings.
- Sub-module idp_seq_decode: purely combinational IR → control bundle (fs, hilo, wr, ysel, dasel, tsel, sext, illegal).
- The FSM in idp_sequencer gates the bundle by state.

Test Plan:
- 0x00221820 (add $3,$1,$2): DECODE S_Addr=1, T_Addr=2. EXEC FS=0x02. WB D_En=1, D_Addr=3, DA_sel=0, Y_Sel=0. done 3 cycles after accept.
- 0x2005FFFF (addi $5,$0,-1) → DT=0xFFFFFFFF, T_Sel=1. WB DA_sel=1, T_Addr=5. 0x3405FFFF (ori) → DT=0x0000FFFF.
- 0x00220018 (mult) → HILO_ld=1 for exactly the EXEC cycle, D_En=0. Then 0x00002012 (mflo $4) → WB Y_Sel=3, D_En=1, D_Addr=4.
- 0x0C000010 (jal) → WB Y_Sel=1, DA_sel=2, D_En=1. 0xFC000000 → illegal=1 with done, D_En=0.
- RESET asserted during EXEC → next cycle state IDLE, instr_ready=1, no D_En. instr_valid held high while busy → exactly one accept per 4 cycles.
- With IDP_SEQ_OVF_TRAP_EN: add with V=1 in EXEC → ovf=1, D_En=0 in WB. Without the macro → D_En=1.
